// File: rtl/gr_rotator_if.sv
`default_nettype none
// ============================================================================
// gr_rotator_if : operand/result bundle for the CORDIC Givens rotator
// Revision 1.0
// ============================================================================
interface gr_rotator_if #(
   parameter int DATA_W      = 12,
   parameter int CORDIC_ITER = 6
);
   logic                     i_trig;
   logic signed [DATA_W-1:0] i_real_a;
   logic signed [DATA_W-1:0] i_imag_a;
   logic signed [DATA_W-1:0] i_real_b;
   logic signed [DATA_W-1:0] i_imag_b;
   logic                     i_mode;
   logic [CORDIC_ITER-1:0]   i_phi_dir;
   logic [CORDIC_ITER-1:0]   i_theta_dir;
   logic signed [DATA_W-1:0] o_real_a;
   logic signed [DATA_W-1:0] o_imag_a;
   logic signed [DATA_W-1:0] o_real_b;
   logic signed [DATA_W-1:0] o_imag_b;
   logic                     o_mode;
   logic                     o_busy;
   logic                     o_finish;

   modport master (
      output i_trig, i_real_a, i_imag_a, i_real_b, i_imag_b,
      output i_mode, i_phi_dir, i_theta_dir,
      input  o_real_a, o_imag_a, o_real_b, o_imag_b,
      input  o_mode, o_busy, o_finish
   );

   modport slave (
      input  i_trig, i_real_a, i_imag_a, i_real_b, i_imag_b,
      input  i_mode, i_phi_dir, i_theta_dir,
      output o_real_a, o_imag_a, o_real_b, o_imag_b,
      output o_mode, o_busy, o_finish
   );
endinterface
`default_nettype wire

// File: rtl/gr_rotator.sv
`default_nettype none
// ============================================================================
// gr_rotator : complex Givens rotator, CORDIC phase pass on b then real pass
// Revision 1.0
// ============================================================================
module gr_rotator #(
   parameter int DATA_W      = 12,
   parameter int CORDIC_ITER = 6,
   parameter int GUARD_W     = 2
) (
   input wire          i_clk,
   input wire          i_rst_n,
   gr_rotator_if.slave bus
);

   localparam int c_W     = DATA_W + GUARD_W;
   localparam int c_CNT_W = (CORDIC_ITER > 1) ? $clog2(CORDIC_ITER) : 1;
   localparam logic [c_CNT_W-1:0]    c_LAST    = c_CNT_W'(CORDIC_ITER - 1);
   localparam logic signed [c_W-1:0] c_SAT_MAX = c_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [c_W-1:0] c_SAT_MIN = c_W'(-(2 ** (DATA_W - 1)));

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PHI   = 3'd1,
      S_SCL1  = 3'd2,
      S_THETA = 3'd3,
      S_SCL2  = 3'd4
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic signed [c_W-1:0]    r_re_a;
   logic signed [c_W-1:0]    r_im_a;
   logic signed [c_W-1:0]    r_re_b;
   logic signed [c_W-1:0]    r_im_b;
   logic                     r_mode;
   logic [CORDIC_ITER-1:0]   r_phi_dir;
   logic [CORDIC_ITER-1:0]   r_theta_dir;
   logic [c_CNT_W-1:0]       r_cnt;

   logic signed [DATA_W-1:0] r_out_re_a;
   logic signed [DATA_W-1:0] r_out_im_a;
   logic signed [DATA_W-1:0] r_out_re_b;
   logic signed [DATA_W-1:0] r_out_im_b;
   logic                     r_out_mode;
   logic                     r_finish;

   logic                     w_trig;
   logic                     w_last;
   logic                     w_dir;
   logic signed [c_W-1:0]    w_xa;
   logic signed [c_W-1:0]    w_ya;
   logic signed [c_W-1:0]    w_sh_xa;
   logic signed [c_W-1:0]    w_sh_ya;
   logic signed [c_W-1:0]    w_sh_xb;
   logic signed [c_W-1:0]    w_sh_yb;
   logic signed [c_W-1:0]    w_xa_n;
   logic signed [c_W-1:0]    w_ya_n;
   logic signed [c_W-1:0]    w_xb_n;
   logic signed [c_W-1:0]    w_yb_n;

   // K ~= 0.607422; every shifted term floors on its own before summing
   function automatic logic signed [c_W-1:0] f_kscale(input logic signed [c_W-1:0] v);
      return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
   endfunction

   function automatic logic signed [DATA_W-1:0] f_sat(input logic signed [c_W-1:0] v);
      logic signed [DATA_W-1:0] r;
      if (v > c_SAT_MAX) begin
         r = c_SAT_MAX[DATA_W-1:0];
      end else if (v < c_SAT_MIN) begin
         r = c_SAT_MIN[DATA_W-1:0];
      end else begin
         r = v[DATA_W-1:0];
      end
      return r;
   endfunction

   assign w_trig = bus.i_trig;
   assign w_last = (r_cnt == c_LAST);

   // Lane A carries (re_b, im_b) in the phase pass and (re_a, re_b) in the Givens pass
   always_comb begin
      w_xa  = r_re_a;
      w_ya  = r_re_b;
      w_dir = r_theta_dir[r_cnt];
      if (r_state == S_PHI) begin
         w_xa  = r_re_b;
         w_ya  = r_im_b;
         w_dir = r_phi_dir[r_cnt];
      end
   end

   assign w_sh_xa = w_xa >>> r_cnt;
   assign w_sh_ya = w_ya >>> r_cnt;
   assign w_sh_xb = r_im_a >>> r_cnt;
   assign w_sh_yb = r_im_b >>> r_cnt;

   assign w_xa_n = w_dir ? (w_xa - w_sh_ya) : (w_xa + w_sh_ya);
   assign w_ya_n = w_dir ? (w_ya + w_sh_xa) : (w_ya - w_sh_xa);
   assign w_xb_n = w_dir ? (r_im_a - w_sh_yb) : (r_im_a + w_sh_yb);
   assign w_yb_n = w_dir ? (r_im_b + w_sh_xb) : (r_im_b - w_sh_xb);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A trigger restarts from any state, abandoning work in flight
   always_comb begin
      w_next_state = r_state;
      if (w_trig) begin
         w_next_state = S_PHI;
      end else begin
         case (r_state)
            S_IDLE:  w_next_state = S_IDLE;
            S_PHI:   if (w_last) w_next_state = S_SCL1;
            S_SCL1:  w_next_state = S_THETA;
            S_THETA: if (w_last) w_next_state = S_SCL2;
            S_SCL2:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_re_a      <= '0;
         r_im_a      <= '0;
         r_re_b      <= '0;
         r_im_b      <= '0;
         r_mode      <= 1'b0;
         r_phi_dir   <= '0;
         r_theta_dir <= '0;
         r_cnt       <= '0;
         r_out_re_a  <= '0;
         r_out_im_a  <= '0;
         r_out_re_b  <= '0;
         r_out_im_b  <= '0;
         r_out_mode  <= 1'b0;
         r_finish    <= 1'b0;
      end else begin
         r_finish <= 1'b0;
         if (w_trig) begin
            r_re_a      <= c_W'(bus.i_real_a);
            r_im_a      <= c_W'(bus.i_imag_a);
            r_re_b      <= c_W'(bus.i_real_b);
            r_im_b      <= c_W'(bus.i_imag_b);
            r_mode      <= bus.i_mode;
            r_phi_dir   <= bus.i_phi_dir;
            r_theta_dir <= bus.i_theta_dir;
            r_cnt       <= '0;
         end else begin
            if ((r_state == S_PHI || r_state == S_THETA) && !w_last) begin
               r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
               r_cnt <= '0;
            end

            // Bypass walks the same state sequence but leaves the operands untouched
            case (r_state)
               S_PHI: begin
                  if (!r_mode) begin
                     r_re_b <= w_xa_n;
                     r_im_b <= w_ya_n;
                  end
               end
               S_SCL1: begin
                  if (!r_mode) begin
                     r_re_b <= f_kscale(r_re_b);
                     r_im_b <= f_kscale(r_im_b);
                  end
               end
               S_THETA: begin
                  if (!r_mode) begin
                     r_re_a <= w_xa_n;
                     r_re_b <= w_ya_n;
                     r_im_a <= w_xb_n;
                     r_im_b <= w_yb_n;
                  end
               end
               S_SCL2: begin
                  if (r_mode) begin
                     r_out_re_a <= f_sat(r_re_a);
                     r_out_im_a <= f_sat(r_im_a);
                     r_out_re_b <= f_sat(r_re_b);
                     r_out_im_b <= f_sat(r_im_b);
                  end else begin
                     r_out_re_a <= f_sat(f_kscale(r_re_a));
                     r_out_im_a <= f_sat(f_kscale(r_im_a));
                     r_out_re_b <= f_sat(f_kscale(r_re_b));
                     r_out_im_b <= f_sat(f_kscale(r_im_b));
                  end
                  r_out_mode <= r_mode;
                  r_finish   <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.o_real_a = r_out_re_a;
   assign bus.o_imag_a = r_out_im_a;
   assign bus.o_real_b = r_out_re_b;
   assign bus.o_imag_b = r_out_im_b;
   assign bus.o_mode   = r_out_mode;
   assign bus.o_busy   = (r_state != S_IDLE);
   assign bus.o_finish = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_gr_rotator.sv
`default_nettype none
// ============================================================================
// tb_gr_rotator : randomized bench against a transaction-level rotator model
// Revision 1.0
// ============================================================================
module tb_gr_rotator;

   localparam int DW  = 12;
   localparam int NI  = 6;
   localparam int LAT = 14;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gr_rotator_if #(.DATA_W(DW), .CORDIC_ITER(NI)) bus ();

   gr_rotator #(.DATA_W(DW), .CORDIC_ITER(NI), .GUARD_W(2)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_checks  = 0;
   int n_errors  = 0;
   int fin_count = 0;
   bit chk_en    = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int ksc(input int v);
      return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
   endfunction

   function automatic int sat(input int v);
      return (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
   endfunction

   function automatic void rot(input int x, input int y, input bit d, input int i,
                               output int xo, output int yo);
      if (d) begin
         xo = x - (y >>> i);
         yo = y + (x >>> i);
      end else begin
         xo = x + (y >>> i);
         yo = y - (x >>> i);
      end
   endfunction

   // Whole-operation result from the arithmetic rules
   function automatic void model_op(input int ra0, input int ia0, input int rb0, input int ib0,
                                    input bit mode, input bit [NI-1:0] pd, input bit [NI-1:0] td,
                                    output int ora, output int oia, output int orb, output int oib);
      int ra, ia, rb, ib;
      ra = ra0; ia = ia0; rb = rb0; ib = ib0;
      if (mode) begin
         ora = ra; oia = ia; orb = rb; oib = ib;
      end else begin
         for (int i = 0; i < NI; i++) rot(rb, ib, pd[i], i, rb, ib);
         rb = ksc(rb);
         ib = ksc(ib);
         for (int i = 0; i < NI; i++) begin
            rot(ra, rb, td[i], i, ra, rb);
            rot(ia, ib, td[i], i, ia, ib);
         end
         ora = sat(ksc(ra)); oia = sat(ksc(ia));
         orb = sat(ksc(rb)); oib = sat(ksc(ib));
      end
   endfunction

   // Greedy vectoring: each step picks the direction that shrinks the b components most
   function automatic void find_dirs(input int ra0, input int ia0, input int rb0, input int ib0,
                                     output bit [NI-1:0] pd, output bit [NI-1:0] td);
      int ra, ia, rb, ib, c0, c1;
      ra = ra0; ia = ia0; rb = rb0; ib = ib0;
      pd = '0;
      td = '0;
      for (int i = 0; i < NI; i++) begin
         c0 = iabs(ib - (rb >>> i));
         c1 = iabs(ib + (rb >>> i));
         pd[i] = (c1 < c0);
         rot(rb, ib, pd[i], i, rb, ib);
      end
      rb = ksc(rb);
      ib = ksc(ib);
      for (int i = 0; i < NI; i++) begin
         c0 = iabs(rb - (ra >>> i)) + iabs(ib - (ia >>> i));
         c1 = iabs(rb + (ra >>> i)) + iabs(ib + (ia >>> i));
         td[i] = (c1 < c0);
         rot(ra, rb, td[i], i, ra, rb);
         rot(ia, ib, td[i], i, ia, ib);
      end
   endfunction

   // Cycle-level expectation: results appear LAT edges after the last trigger
   int e_ra = 0, e_ia = 0, e_rb = 0, e_ib = 0, e_mode = 0, e_fin = 0;
   int p_ra = 0, p_ia = 0, p_rb = 0, p_ib = 0, p_mode = 0;
   int m_cnt = 0;
   int m_pend = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_ra = 0; e_ia = 0; e_rb = 0; e_ib = 0; e_mode = 0; e_fin = 0;
         m_cnt = 0; m_pend = 0;
      end else begin
         e_fin = 0;
         if (bus.i_trig) begin
            model_op(bus.i_real_a, bus.i_imag_a, bus.i_real_b, bus.i_imag_b,
                     bus.i_mode, bus.i_phi_dir, bus.i_theta_dir, p_ra, p_ia, p_rb, p_ib);
            p_mode = int'(bus.i_mode);
            m_cnt  = LAT;
            m_pend = 1;
         end else if (m_pend != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               e_ra = p_ra; e_ia = p_ia; e_rb = p_rb; e_ib = p_ib;
               e_mode = p_mode;
               e_fin  = 1;
               m_pend = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("o_real_a", bus.o_real_a, e_ra);
         check("o_imag_a", bus.o_imag_a, e_ia);
         check("o_real_b", bus.o_real_b, e_rb);
         check("o_imag_b", bus.o_imag_b, e_ib);
         check("o_mode",   int'(bus.o_mode),   e_mode);
         check("o_busy",   int'(bus.o_busy),   m_pend);
         check("o_finish", int'(bus.o_finish), e_fin);
         if (bus.o_finish) fin_count++;
      end
   end

   task automatic scramble();
      bus.i_real_a    = DW'($urandom);
      bus.i_imag_a    = DW'($urandom);
      bus.i_real_b    = DW'($urandom);
      bus.i_imag_b    = DW'($urandom);
      bus.i_mode      = 1'($urandom);
      bus.i_phi_dir   = NI'($urandom);
      bus.i_theta_dir = NI'($urandom);
   endtask

   task automatic set_ops(input int ra, input int ia, input int rb, input int ib,
                          input bit mode, input bit [NI-1:0] pd, input bit [NI-1:0] td);
      bus.i_real_a    = DW'(ra);
      bus.i_imag_a    = DW'(ia);
      bus.i_real_b    = DW'(rb);
      bus.i_imag_b    = DW'(ib);
      bus.i_mode      = mode;
      bus.i_phi_dir   = pd;
      bus.i_theta_dir = td;
      bus.i_trig      = 1'b1;
   endtask

   task automatic release_trig();
      @(posedge clk);
      #2;
      bus.i_trig = 1'b0;
      scramble();
   endtask

   task automatic trig_op(input int ra, input int ia, input int rb, input int ib,
                          input bit mode, input bit [NI-1:0] pd, input bit [NI-1:0] td);
      @(posedge clk);
      #2;
      set_ops(ra, ia, rb, ib, mode, pd, td);
      release_trig();
   endtask

   task automatic wait_finish(output int cyc, output int bcyc);
      cyc  = 0;
      bcyc = 0;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.o_busy) bcyc++;
         if (bus.o_finish) break;
      end
      check("finish_seen", int'(bus.o_finish), 1);
   endtask

   function automatic int rnd_s();
      return int'($urandom_range(0, 4095)) - 2048;
   endfunction

   initial begin
      int cyc, bcyc, snap, mag2, variant, ra, ia, rb, ib;
      bit [NI-1:0] pd, td;
      bit md;

      bus.i_trig = 1'b0;
      set_ops(0, 0, 0, 0, 1'b0, '0, '0);
      bus.i_trig = 1'b0;

      repeat (3) @(posedge clk);
      #2;
      check("rst_real_a", bus.o_real_a, 0);
      check("rst_imag_a", bus.o_imag_a, 0);
      check("rst_real_b", bus.o_real_b, 0);
      check("rst_imag_b", bus.o_imag_b, 0);
      check("rst_busy",   int'(bus.o_busy),   0);
      check("rst_finish", int'(bus.o_finish), 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      repeat (3) @(posedge clk);

      // Bypass
      trig_op(256, -128, 0, 512, 1'b1, NI'($urandom), NI'($urandom));
      wait_finish(cyc, bcyc);
      check("byp_latency",  cyc, 15);
      check("byp_busy_cyc", bcyc, 14);
      check("byp_real_a", bus.o_real_a, 256);
      check("byp_imag_a", bus.o_imag_a, -128);
      check("byp_real_b", bus.o_real_b, 0);
      check("byp_imag_b", bus.o_imag_b, 512);
      check("byp_mode",   int'(bus.o_mode), 1);

      // Givens pass only, all directions 0
      trig_op(256, 0, 0, 0, 1'b0, NI'($urandom), '0);
      wait_finish(cyc, bcyc);
      check("theta_real_a", bus.o_real_a, -37);
      check("theta_imag_a", bus.o_imag_a, 0);
      check("theta_real_b", bus.o_real_b, -252);
      check("theta_imag_b", bus.o_imag_b, 0);
      check("theta_mode",   int'(bus.o_mode), 0);

      // Vectoring
      find_dirs(256, 0, 256, 0, pd, td);
      trig_op(256, 0, 256, 0, 1'b0, pd, td);
      wait_finish(cyc, bcyc);
      mag2 = int'(bus.o_real_a) * int'(bus.o_real_a) + int'(bus.o_imag_a) * int'(bus.o_imag_a);
      check("vec_real_b_small", int'(iabs(bus.o_real_b) <= 12), 1);
      check("vec_imag_b_small", int'(iabs(bus.o_imag_b) <= 12), 1);
      check("vec_mag_a", int'(mag2 >= 356 * 356 && mag2 <= 368 * 368), 1);

      // Saturation: vectored full-scale input must clip positive
      find_dirs(2047, 2047, 2047, 2047, pd, td);
      trig_op(2047, 2047, 2047, 2047, 1'b0, pd, td);
      wait_finish(cyc, bcyc);
      check("sat_real_a", bus.o_real_a, 2047);
      for (int k = 0; k < 3; k++) begin
         trig_op(2047, 2047, 2047, 2047, 1'b0, NI'($urandom), NI'($urandom));
         wait_finish(cyc, bcyc);
      end

      // Retrigger at E5
      @(posedge clk);
      #2;
      snap = fin_count;
      trig_op(300, -700, 1000, 50, 1'b0, NI'($urandom), NI'($urandom));
      repeat (3) @(posedge clk);
      trig_op(-900, 400, -200, 1500, 1'b0, NI'($urandom), NI'($urandom));
      wait_finish(cyc, bcyc);
      check("retrig_latency", cyc, 15);
      @(posedge clk);
      #2;
      check("retrig_fin_count", fin_count - snap, 1);

      // Trigger coinciding with o_finish
      trig_op(rnd_s(), rnd_s(), rnd_s(), rnd_s(), 1'b0, NI'($urandom), NI'($urandom));
      wait_finish(cyc, bcyc);
      set_ops(rnd_s(), rnd_s(), rnd_s(), rnd_s(), 1'b0, NI'($urandom), NI'($urandom));
      release_trig();
      wait_finish(cyc, bcyc);
      check("b2b_latency", cyc, 15);

      // Randomized operations with occasional retrigger / back-to-back starts
      for (int k = 0; k < 24; k++) begin
         ra = rnd_s(); ia = rnd_s(); rb = rnd_s(); ib = rnd_s();
         md = ($urandom_range(0, 3) == 0);
         variant = int'($urandom_range(0, 3));
         trig_op(ra, ia, rb, ib, md, NI'($urandom), NI'($urandom));
         if (variant == 0) begin
            repeat ($urandom_range(0, 11)) @(posedge clk);
            trig_op(rnd_s(), rnd_s(), rnd_s(), rnd_s(), 1'b0, NI'($urandom), NI'($urandom));
         end
         wait_finish(cyc, bcyc);
         if (variant == 1) begin
            set_ops(rnd_s(), rnd_s(), rnd_s(), rnd_s(), md, NI'($urandom), NI'($urandom));
            release_trig();
            wait_finish(cyc, bcyc);
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      // Reset in the middle of an operation (asserted at E9)
      trig_op(1200, -300, 700, 900, 1'b0, NI'($urandom), NI'($urandom));
      snap = fin_count;
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_real_a", bus.o_real_a, 0);
      check("midrst_imag_a", bus.o_imag_a, 0);
      check("midrst_real_b", bus.o_real_b, 0);
      check("midrst_imag_b", bus.o_imag_b, 0);
      check("midrst_busy",   int'(bus.o_busy), 0);
      check("midrst_finish", int'(bus.o_finish), 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      check("midrst_no_finish", fin_count - snap, 0);
      check("midrst_idle", int'(bus.o_busy), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/gr_rotator.md
GR_ROTATOR -- requirements
Module: gr_rotator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, meaning I/O sample width, signed S3.8 (1.0 = 256).
REQ-002 The block SHALL have parameter CORDIC_ITER, default 6, meaning micro-rotations per CORDIC pass.
REQ-003 The block SHALL have parameter GUARD_W, default 2, meaning extra integer bits in the internal datapath.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The port list, clock and reset first, SHALL be:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_trig  in  1  start pulse; operands sampled on this edge.
- i_real_a, i_imag_a  in  DATA_W each  top-row element a, signed.
- i_real_b, i_imag_b  in  DATA_W each  bottom-row element b, signed; delay-unit x output.
- i_mode  in  1  delay-unit mode bit; 1 = bypass, 0 = rotate.
- i_phi_dir  in  CORDIC_ITER  phase-pass directions; bit i is used at iteration i.
- i_theta_dir  in  CORDIC_ITER  Givens-pass directions; bit i is used at iteration i.
- o_real_a, o_imag_a, o_real_b, o_imag_b  out  DATA_W each  rotated results, registered.
- o_mode  out  1  latched i_mode, aligned with the results.
- o_busy  out  1  high from the edge after the trigger through the output-write edge.
- o_finish  out  1  one-cycle pulse: results valid.

Function
REQ-006 On i_trig, the block SHALL latch the a, b, i_mode, i_phi_dir and i_theta_dir inputs on edge E0, sign-extended to DATA_W+GUARD_W bits.
REQ-007 The state machine SHALL have states IDLE, PHI, SCL1, THETA, SCL2, and SHALL move IDLE->PHI at E0.
REQ-008 In PHI, edges E1..E6 SHALL perform phase iterations i = 0..5 on the pair (re_b, im_b).
REQ-009 In SCL1, edge E7 SHALL scale re_b and im_b by K.
REQ-010 In THETA, edges E8..E13 SHALL perform Givens iterations i = 0..5 on (re_a, re_b) and (im_a, im_b) in parallel, with the same direction bit applied to both pairs.
REQ-011 In SCL2, edge E14 SHALL scale all four values by K, saturate them, write the outputs and o_mode, and return to IDLE.
REQ-012 A micro-rotation with direction bit 1 SHALL compute x' = x - (y>>>i), y' = y + (x>>>i).
REQ-013 A micro-rotation with direction bit 0 SHALL compute x' = x + (y>>>i), y' = y - (x>>>i).
REQ-014 Shifts SHALL be arithmetic with floor rounding; x is re_b in PHI and the a-component in THETA.
REQ-015 K scaling SHALL be the shift-add v>>>1 + v>>>3 - v>>>6 - v>>>9 (K = 0.607422), with each term truncated.
REQ-016 Output saturation SHALL clip to [-2048, 2047] for DATA_W = 12 and SHALL never wrap.
REQ-017 In bypass mode (i_mode = 1), the block SHALL pass the latched operands to the outputs unchanged at E14 with identical timing and state sequence.
REQ-018 o_finish SHALL be 1 for exactly the one cycle following E14, and 0 at all other times.
REQ-019 o_busy SHALL be 1 in PHI, SCL1, THETA and SCL2, and 0 in IDLE.
REQ-020 The outputs SHALL hold their last written values until the next E14.
REQ-021 i_trig SHALL have priority in every state: if asserted while busy, the block SHALL abandon the current operation, relatch all operands and restart at E0.
REQ-022 An abandoned operation SHALL produce no o_finish.
REQ-023 If i_trig coincides with o_finish high, the block SHALL start a new operation, and o_finish SHALL still fall on the next edge.
REQ-024 Direction inputs SHALL be ignored outside the trigger edge.

Reset
REQ-025 While i_rst_n = 0, all outputs SHALL be 0, the state SHALL be IDLE, and all internal registers and the iteration counter SHALL be 0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no o_finish, and the outputs SHALL read 0.
REQ-027 After i_rst_n releases, the block SHALL stay in IDLE until the next i_trig.

Verification
REQ-028 Bypass: a = (256, -128), b = (0, 512), i_mode = 1, trig at E0 -> o_finish only in the cycle after E14; outputs (256, -128, 0, 512); o_mode = 1; o_busy high for exactly 14 cycles.
REQ-029 Theta only: a = (256, 0), b = (0, 0), i_theta_dir = 6'b000000 -> o_real_a = -36 ±3, o_real_b = -253 ±3, imaginary outputs 0.
REQ-030 Vectoring: a = (256, 0), b = (256, 0), i_phi_dir and i_theta_dir from the bit-accurate model -> o_real_b and o_imag_b within ±12 of 0, |a| = 362 ±6; all four outputs bit-exact against the model.
REQ-031 Saturation: all inputs 2047, i_mode = 0, random direction bits -> outputs clipped to the range [-2048, 2047] with no sign flip, matching the model.
REQ-032 Retrigger: second i_trig at E5 with new operands -> no o_finish for the first operation; o_finish 14 edges after the second trigger with the second operation's results.
REQ-033 Reset mid-operation: i_rst_n low at E9 for 2 cycles -> outputs 0 immediately, no o_finish, IDLE until the next i_trig.
